viking_fetch_responder: RTL and testbench
=========================================

# viking_fetch_responder

Memory-side responder for the Viking/SM194 video fetcher's 64-bit read requests. It detects each new fetch request and breaks it into four sequential 16-bit reads on the word-wide memory port. It assembles the four words into one 64-bit data word and holds that word stable for the fetcher's latch point. It sits between the video fetcher and the memory arbiter, on the memory clock.

## Interface
Parameters:
- `MAX_WAIT`, 15: ack-timeout limit in clocks, per word. Valid range 1–255.

Ports:
- `clk`  in  1  memory clock; the only clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `bus_cycle`  in  2  current bus slot; video reads are legal only in slot 2.
- `addr`  in  23  video word address; `addr[1:0]` is ignored (forced 0).
- `read`  in  1  video read request; held high for the whole slot-2 window.
- `data`  out  64  assembled fetch result.
- `done`  out  1  one-clock pulse when `data` updates.
- `mem_req`  out  1  word read request to the arbiter.
- `mem_addr`  out  23  word address for `mem_req`.
- `mem_ack`  in  1  one-clock acknowledge; `mem_rdata` is valid in the same clock.
- `mem_rdata`  in  16  returned word.
- `overrun`  out  8  saturating count of requests dropped because the responder was busy.
- `timeout`  out  1  sticky flag: a word exceeded `MAX_WAIT`; cleared only by reset.

## Operation
- Start condition: `read` high, `bus_cycle`==2, and `read` was low on the previous clock (rising edge, registered).
  - On start, latch `base = {addr[22:2],2'b00}`, set word index k=0, and enter REQ.
- States:
  - IDLE: `mem_req`=0.
    - Start → REQ.
  - REQ: `mem_req`=1 and `mem_addr`=base+k, both held stable until `mem_ack`.
    - On ack: store `mem_rdata` into shadow slot k, with k=0→[15:0], k=1→[31:16], k=2→[47:32], k=3→[63:48].
    - If k<3: k++ and stay in REQ. `mem_addr` advances in the next clock and `mem_req` stays high with no gap.
    - If k==3: go to DONE.
  - DONE: copy the shadow register into `data` atomically, pulse `done`=1, deassert `mem_req`, return to IDLE.
- Address arithmetic: base+k is a 23-bit add that wraps modulo 2^23. base=7FFFFC fetches 7FFFFC..7FFFFF; no carry leaves the block.
- Busy collision: a start condition outside IDLE does not begin a new fetch. `overrun` increments and saturates at FF; the current burst continues.
- Timeout:
  - A per-word wait counter clears on entry to each word and counts clocks with `mem_req`=1 and no ack.
  - When it reaches `MAX_WAIT`:
    - set `timeout`;
    - store 16'hFFFF in slot k (blank/white pixels);
    - treat the word as acked.
  - The burst always completes in bounded time.
- `data` is never partially updated. Between `done` pulses it holds its previous value.
- Simultaneous `mem_ack` and timeout expiry in the same clock: the ack wins; `mem_rdata` is stored and `timeout` is not set.

## Timing
- Reset values: `data`=0, `done`=0, `mem_req`=0, `mem_addr`=0, `overrun`=0, `timeout`=0, state IDLE, k=0.
- Reset asserted mid-burst: `mem_req` drops asynchronously and the shadow register is discarded. After release, a new start is needed: `read` must be seen low, then high.
- Start to first `mem_req`: 1 clock. The clock after the edge is detected shows `mem_req`=1 with `mem_addr`=base.
- With zero-wait acks (ack in the first cycle of each request), latency from start to `done` is 6 clocks: 1 detect, 4 words, 1 DONE.
- Each wait cycle per word adds 1 clock.
- Integration requirement: the worst-case burst must complete before the fetcher latches at the end of slot 2. The fetcher latches 47 clocks of a 128 MHz clock after slot 2 begins; at a 128 MHz `clk` this gives a budget of 47 clocks.
- `done` is high for exactly 1 clock, in the same clock that `data` changes.

## Test plan
- Zero-wait burst:
  - Stimulus: addr=600000, memory returns 1111, 2222, 3333, 4444.
  - Response: `mem_addr` sequence 600000..600003; `data`=4444_3333_2222_1111; `done` is 6 clocks after the `read` rise.
- Wait states:
  - Stimulus: ack delays of 0, 3, 1, 2 cycles.
  - Response: `done` at clock 12; `mem_req` held continuously; `mem_addr` stable during each wait.
- Address wrap and low-bit masking:
  - Stimulus: addr=7FFFFE.
  - Response: fetches 7FFFFC..7FFFFF.
- Busy collision:
  - Stimulus: `read` toggles low then high mid-burst, repeated 300 times.
  - Response: the first burst completes with correct data; `overrun`=FF and no higher.
- Timeout:
  - Stimulus: `MAX_WAIT`=15; word 2 is never acked.
  - Response: `timeout`=1 after 15 wait clocks; `data[47:32]`=FFFF; the other slots hold the returned data; `done` asserted.
  - Extra case: an ack arriving on the 15th wait clock leaves `timeout`=0.
- Reset mid-burst:
  - Stimulus: pull `reset_n` low after word 1's ack.
  - Response: `mem_req`=0 immediately; all outputs at reset values; no `done` pulse; the next rising edge of `read` starts a fresh fetch.

Source files
------------

// File: rtl/viking_fetch_responder.sv
// Memory-side responder for the Viking/SM194 video fetcher: splits one 64-bit
// read into four 16-bit word reads and presents the assembled word atomically.
module viking_fetch_responder #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  bus_cycle,
    input  logic [22:0] addr,
    input  logic        read,
    output logic [63:0] data,
    output logic        done,
    output logic        mem_req,
    output logic [22:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [7:0]  overrun,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_nx;
    logic        read_q;
    logic [22:0] base;
    logic [1:0]  k;
    logic [7:0]  wait_cnt;
    logic [63:0] shadow;
    logic        start;
    logic        expire;
    logic        word_end;

    // The two address LSBs select a word inside the 64-bit group and are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign start    = read && !read_q && (bus_cycle == 2'd2);
    // An ack in the expiry clock wins, so expiry is qualified by the absence of ack.
    assign expire   = !mem_ack && (wait_cnt == WAIT_LAST);
    assign word_end = (state == REQ) && (mem_ack || expire);

    assign mem_req  = (state == REQ);
    assign mem_addr = base + 23'(k);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = REQ;
            REQ:     if (word_end && (k == 2'd3)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // NOTE: read_q resets high so a read held across reset cannot look like a new edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) read_q <= 1'b1;
        else          read_q <= read;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base     <= '0;
            k        <= '0;
            wait_cnt <= '0;
            shadow   <= '0;
            timeout  <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                base     <= {addr[22:2], 2'b00};
                k        <= '0;
                wait_cnt <= '0;
            end else if (word_end) begin
                shadow[{k, 4'b0000} +: 16] <= mem_ack ? mem_rdata : 16'hFFFF;
                if (expire) timeout <= 1'b1;
                k        <= k + 2'd1;
                wait_cnt <= '0;
            end else if (state == REQ) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == DONE) begin
                data <= shadow;
                done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= '0;
        end else if (start && (state != IDLE) && (overrun != 8'hFF)) begin
            overrun <= overrun + 8'd1;
        end
    end

endmodule

// File: tb/tb_viking_fetch_responder.sv
// Randomized bench for viking_fetch_responder against a burst-level timing model.
module tb_viking_fetch_responder;

    localparam int MW = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  bus_cycle;
    logic [22:0] addr;
    logic        read;
    logic [63:0] data;
    logic        done;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [7:0]  overrun;
    logic        timeout;

    viking_fetch_responder #(.MAX_WAIT(MW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus_cycle (bus_cycle),
        .addr      (addr),
        .read      (read),
        .data      (data),
        .done      (done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_data = '0;
    logic [7:0]  exp_ovr  = '0;
    logic        exp_to   = 1'b0;
    int          dly[4];
    logic [15:0] wd[4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One fetch: word k spends dly+1 clocks if acked in time, else MW clocks and reads FFFF.
    task automatic run_burst(input logic [22:0] a, input bit toggle);
        logic [22:0] base;
        int          c[4];
        int          s[5];
        logic [63:0] img;
        bit          r_prev;
        bit          r_now;
        int          k;
        base = {a[22:2], 2'b00};
        s[0] = 0;
        for (int i = 0; i < 4; i++) begin
            if (dly[i] < MW) begin
                c[i] = dly[i] + 1;
                img[i*16 +: 16] = wd[i];
            end else begin
                c[i] = MW;
                img[i*16 +: 16] = 16'hFFFF;
                exp_to = 1'b1;
            end
            s[i+1] = s[i] + c[i];
        end
        @(negedge clk);
        read = 1'b1; bus_cycle = 2'd2; addr = a; mem_ack = 1'b0;
        r_prev = 1'b1;
        for (int t = 0; t <= s[4] + 1; t++) begin
            @(posedge clk); #1;
            k = 0;
            while (k < 3 && t >= s[k+1]) k++;
            check("mem_req", 64'(mem_req), 64'(t < s[4]));
            if (t < s[4]) check("mem_addr", 64'(mem_addr), 64'(base + 23'(k)));
            check("done", 64'(done), 64'(t == s[4] + 1));
            check("data", data, (t == s[4] + 1) ? img : exp_data);
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            if (t < s[4] && (t - s[k]) == dly[k]) begin
                mem_ack = 1'b1;
                mem_rdata = wd[k];
            end
            r_now = (t <= s[4]) ? (toggle ? ((t % 2) != 0) : 1'b1) : 1'b0;
            if (r_now && !r_prev) exp_ovr = (exp_ovr == 8'hFF) ? 8'hFF : exp_ovr + 8'd1;
            read = r_now;
            r_prev = r_now;
            bus_cycle = toggle ? 2'd2 : 2'($urandom);
            addr = 23'($urandom);
        end
        exp_data = img;
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'(0));
        check("data_hold", data, exp_data);
        check("overrun", 64'(overrun), 64'(exp_ovr));
        check("timeout", 64'(timeout), 64'(exp_to));
    endtask

    task automatic set_burst(input int d0, input int d1, input int d2, input int d3,
                             input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        wd[0]  = w0; wd[1]  = w1; wd[2]  = w2; wd[3]  = w3;
    endtask

    initial begin
        reset_n = 1'b0; read = 1'b0; bus_cycle = 2'd0; addr = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_data", data, 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        #20;
        @(negedge clk) reset_n = 1'b1;

        // A read edge outside slot 2 must not start a fetch.
        @(negedge clk); read = 1'b1; bus_cycle = 2'd1;
        repeat (4) begin
            @(posedge clk); #1;
            check("slot_gate_req", 64'(mem_req), 64'(0));
        end
        @(negedge clk) read = 1'b0;

        set_burst(0, 0, 0, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        run_burst(23'h600000, 1'b0);
        set_burst(0, 3, 1, 2, 16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0789);
        run_burst(23'h600000, 1'b0);
        set_burst(0, 1, 0, 2, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
        run_burst(23'h7FFFFE, 1'b0);
        set_burst(0, 0, MW - 1, 0, 16'hBEEF, 16'hCAFE, 16'hD00D, 16'hF00D);
        run_burst(23'h0ABCD1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            set_burst($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 4), 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom));
            run_burst(23'($urandom), 1'b0);
        end

        for (int n = 0; n < 15; n++) begin
            set_burst(10, 10, 10, 10, 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom));
            run_burst(23'($urandom), 1'b1);
        end

        set_burst(0, 2, 1000, 1, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
        run_burst(23'h400010, 1'b0);

        for (int n = 0; n < 8; n++) begin
            set_burst($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                      $urandom_range(0, 20), 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom));
            run_burst(23'($urandom), 1'b0);
        end

        // Reset after word 1 is acked: everything returns to reset values at once.
        @(negedge clk); read = 1'b1; bus_cycle = 2'd2; addr = 23'h123454;
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 16'h9999;
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 16'hAAAA;
        @(posedge clk); #1; mem_ack = 1'b0;
        check("pre_rst_req", 64'(mem_req), 64'(1));
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", 64'(mem_req), 64'(0));
        check("mid_rst_addr", 64'(mem_addr), 64'(0));
        check("mid_rst_data", data, 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_overrun", 64'(overrun), 64'(0));
        check("mid_rst_timeout", 64'(timeout), 64'(0));
        exp_data = '0; exp_ovr = '0; exp_to = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_req", 64'(mem_req), 64'(0));
            check("post_rst_done", 64'(done), 64'(0));
        end
        @(negedge clk) read = 1'b0;
        set_burst(1, 0, 2, 0, 16'h1357, 16'h2468, 16'h9ACE, 16'hBDF0);
        run_burst(23'h123454, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
